// File: rtl/rsa_pkg.sv
// Shared constants, FSM state type and RSA test-vector values for the modexp engine.
package rsa_pkg;

  localparam int RSA_WIDTH = 16;
  localparam int RSA_EXP_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SQR,
    MUL,
    DONE
  } modexp_state_t;

  // Textbook key pair for p=61, q=53; d matches the key-computation block output.
  localparam int RSA_N = 3233;
  localparam int RSA_E = 17;
  localparam int RSA_D = 2753;

endpackage

// File: rtl/rsa_modmul.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n, MSB-first over a, WIDTH cycles.
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] p,
  output logic             mul_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_p;
  logic [CW-1:0]    w_bitIdx;
  logic [WIDTH-1:0] w_pIn;
  logic [WIDTH-1:0] w_red1;
  logic [WIDTH:0]   w_nExt;
  logic [WIDTH:0]   w_dbl;
  logic [WIDTH:0]   w_bSel;
  logic [WIDTH:0]   w_sum;

  // One interleaved step; the first step of a multiply starts from p=0 so back-to-back
  // multiplies need no idle cycle. p is the post-step value, the product when mul_done is high.
  always_comb begin
    w_bitIdx = CW'(WIDTH - 1) - r_cnt;
    w_pIn    = (r_cnt == '0) ? '0 : r_p;
    w_nExt   = {1'b0, n};
    w_dbl    = {w_pIn, 1'b0};
    w_red1   = WIDTH'((w_dbl >= w_nExt) ? (w_dbl - w_nExt) : w_dbl);
    w_bSel   = a[w_bitIdx] ? {1'b0, b} : '0;
    w_sum    = {1'b0, w_red1} + w_bSel;
    p        = WIDTH'((w_sum >= w_nExt) ? (w_sum - w_nExt) : w_sum);
  end

  assign mul_done = go && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_p   <= '0;
    end else if (go) begin
      r_p   <= p;
      r_cnt <= mul_done ? '0 : r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/rsa_modexp.sv
// Modular exponentiation result = base^exp mod n by left-to-right square-and-multiply.
// Define RSA_MODEXP_SKIP_ZEROS_EN to skip leading-zero squarings (data-dependent timing).
module rsa_modexp
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH,
  parameter int EXP_W = RSA_EXP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [EXP_W-1:0] exp,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  modexp_state_t    r_state;
  modexp_state_t    w_stateNext;
  logic [WIDTH-1:0] r_base;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [EXP_W-1:0] r_exp;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    w_idxInit;
  logic             r_err;
  logic             w_go;
  logic             w_mulDone;
  logic             w_opErr;
  logic             w_curBit;
  logic             w_lastBit;
  logic [WIDTH-1:0] w_mulB;
  logic [WIDTH-1:0] w_prod;

  assign w_opErr   = (r_n < WIDTH'(2)) || (r_base >= r_n);
  assign w_curBit  = r_exp[r_idx];
  assign w_lastBit = (r_idx == '0);

  always_comb begin
    w_idxInit = IW'(EXP_W - 1);
`ifdef RSA_MODEXP_SKIP_ZEROS_EN
    w_idxInit = '0;
    for (int k = 0; k < EXP_W; k++) begin
      if (r_exp[k]) w_idxInit = IW'(k);
    end
`endif
  end

  rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (w_go),
    .a        (r_acc),
    .b        (w_mulB),
    .n        (r_n),
    .p        (w_prod),
    .mul_done (w_mulDone)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_go        = 1'b0;
    w_mulB      = r_acc;
    case (r_state)
      IDLE: if (start) w_stateNext = CHECK;
      CHECK: begin
        if (w_opErr) w_stateNext = DONE;
`ifdef RSA_MODEXP_SKIP_ZEROS_EN
        else if (r_exp == '0) w_stateNext = DONE;
`endif
        else w_stateNext = SQR;
      end
      SQR: begin
        w_go = 1'b1;
        if (w_mulDone) begin
          if (w_curBit)       w_stateNext = MUL;
          else if (w_lastBit) w_stateNext = DONE;
        end
      end
      MUL: begin
        w_go   = 1'b1;
        w_mulB = r_base;
        if (w_mulDone) w_stateNext = w_lastBit ? DONE : SQR;
      end
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // The bit index only moves on once both the square and any multiply for that bit are done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_base   <= '0;
      r_exp    <= '0;
      r_n      <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_base <= base;
            r_exp  <= exp;
            r_n    <= n;
          end
        end
        CHECK: begin
          r_acc <= WIDTH'(1);
          r_idx <= w_idxInit;
          if (w_opErr) begin
            r_result <= '0;
            r_err    <= 1'b1;
          end
`ifdef RSA_MODEXP_SKIP_ZEROS_EN
          else if (r_exp == '0) begin
            r_result <= WIDTH'(1);
            r_err    <= 1'b0;
          end
`endif
        end
        SQR, MUL: begin
          if (w_mulDone) begin
            r_acc <= w_prod;
            if (w_stateNext == DONE) begin
              r_result <= w_prod;
              r_err    <= 1'b0;
            end
            if (w_stateNext != MUL && !w_lastBit) r_idx <= r_idx - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state == CHECK) || (r_state == SQR) || (r_state == MUL);
  assign done   = (r_state == DONE);
  assign result = r_result;
  assign err    = r_err;

endmodule
